openddr_apb_master: RTL and testbench



---
 rtl/openddr_apb_master.sv | 173 +++++++++++++++++
 tb/tb_openddr_apb_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/openddr_apb_master.sv
// APB requester for the OpenDDR configuration space: converts single valid/ready
// register commands into APB SETUP/ACCESS transfers with a hung-slave timeout.
module openddr_apb_master #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State and output registers; reset drops the APB strobes and any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error without touching the bus
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_openddr_apb_master.sv
// Bench for openddr_apb_master: a transaction-level model expands each command into
// its expected per-cycle output trace, checked every cycle, plus literal spot checks.
module tb_openddr_apb_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  openddr_apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cmd_ready;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   psel_cnt = 0;
  int   pen_cnt = 0;

  int          slave_waits = 0;
  logic        slave_err = 1'b0;
  logic [31:0] slave_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // APB slave: asserts pready in ACCESS cycle slave_waits+1
  initial begin
    int acc_n;
    acc_n = 0;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        acc_n++;
        pready  = (acc_n > slave_waits);
        prdata  = pready ? slave_rdata : 32'h0;
        pslverr = pready ? slave_err : 1'b0;
      end else begin
        acc_n   = 0;
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model trace
  initial begin
    obs_t e, a;
    bit   ok;
    forever begin
      @(negedge clk);
      if (psel) psel_cnt++;
      if (penable) pen_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{cmd_ready, psel, penable, pwrite, paddr, pwdata,
              rsp_valid, rsp_rdata, rsp_err, rsp_timeout};
        ok = (a.cmd_ready === e.cmd_ready) && (a.psel === e.psel) &&
             (a.penable === e.penable) && (a.rsp_valid === e.rsp_valid);
        if (e.psel)
          ok = ok && (a.pwrite === e.pwrite) && (a.paddr === e.paddr) && (a.pwdata === e.pwdata);
        if (e.rsp_valid)
          ok = ok && (a.rsp_rdata === e.rsp_rdata) && (a.rsp_err === e.rsp_err) &&
               (a.rsp_timeout === e.rsp_timeout);
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL cycle_trace t=%0t: got=%h expected=%h", $time, a, e);
        end
      end
    end
  end

  int          lat_seen;
  logic [31:0] rdata_seen;
  logic        err_seen, to_seen;

  // One command: build the expected trace from transaction-level rules, then drive it
  task automatic do_txn(input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                        input int waits, input bit serr, input logic [31:0] rd, input int hold);
    obs_t r;
    bit   aligned, timed_out;
    int   n_acc;
    bit   found;
    aligned   = (addr[1:0] == 2'b00);
    timed_out = aligned && (waits >= TO);
    n_acc     = (waits < TO) ? waits + 1 : TO;
    slave_waits = waits;
    slave_err   = serr;
    slave_rdata = rd;
    psel_cnt = 0;
    pen_cnt  = 0;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    if (aligned) begin
      r = '0; r.psel = 1'b1; r.pwrite = wr; r.paddr = addr; r.pwdata = wr ? wd : 32'h0;
      exp_q.push_back(r);
      r.penable = 1'b1;
      repeat (n_acc) exp_q.push_back(r);
    end
    r = '0;
    r.rsp_valid   = 1'b1;
    r.rsp_err     = !aligned || timed_out || serr;
    r.rsp_timeout = timed_out;
    r.rsp_rdata   = (aligned && !timed_out && !wr && !serr) ? rd : 32'h0;
    repeat (hold + 1) exp_q.push_back(r);
    r = '0; r.cmd_ready = 1'b1;
    exp_q.push_back(r);

    found = 0;
    lat_seen = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat_seen = i;
        found = 1;
        break;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL rsp_wait: got=no rsp_valid expected=rsp_valid within 100 cycles");
      exp_q.delete();
      return;
    end
    rdata_seen = rsp_rdata; err_seen = rsp_err; to_seen = rsp_timeout;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got=%0d left expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_cmd_ready", 32'(cmd_ready), 0);
    check("reset_psel", 32'(psel), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", 32'(cmd_ready), 1);

    // 1: write, one wait state
    do_txn(1'b1, 10'h020, 32'h0000_00AA, 1, 1'b0, 32'hDEAD_BEEF, 0);
    check("t1_psel_cycles", 32'(psel_cnt), 3);
    check("t1_penable_cycles", 32'(pen_cnt), 2);
    check("t1_latency", 32'(lat_seen), 4);
    check("t1_rdata", rdata_seen, 32'h0);

    // 2: zero-wait read
    do_txn(1'b0, 10'h008, 32'h5555_5555, 0, 1'b0, 32'h1234_5678, 0);
    check("t2_latency", 32'(lat_seen), 3);
    check("t2_rdata", rdata_seen, 32'h1234_5678);
    check("t2_err", 32'(err_seen), 0);

    // 3: slave error on read
    do_txn(1'b0, 10'h010, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 0);
    check("t3_err", 32'(err_seen), 1);
    check("t3_timeout", 32'(to_seen), 0);
    check("t3_rdata", rdata_seen, 32'h0);

    // 4: hung slave times out after TIMEOUT access cycles
    do_txn(1'b0, 10'h030, 32'h0, 1000, 1'b0, 32'h1111_2222, 0);
    check("t4_access_cycles", 32'(pen_cnt), 16);
    check("t4_err", 32'(err_seen), 1);
    check("t4_timeout", 32'(to_seen), 1);

    // 4b: pready on the expiry cycle wins
    do_txn(1'b0, 10'h034, 32'h0, 15, 1'b0, 32'hA5A5_0001, 0);
    check("t4b_access_cycles", 32'(pen_cnt), 16);
    check("t4b_timeout", 32'(to_seen), 0);
    check("t4b_rdata", rdata_seen, 32'hA5A5_0001);

    // 5: misaligned address
    do_txn(1'b1, 10'h006, 32'h0000_0077, 0, 1'b0, 32'h0, 0);
    check("t5_psel_cycles", 32'(psel_cnt), 0);
    check("t5_latency", 32'(lat_seen), 1);
    check("t5_err", 32'(err_seen), 1);

    // 6: response back-pressure for 5 cycles
    do_txn(1'b0, 10'h3FC, 32'h0, 3, 1'b0, 32'h8765_4321, 5);
    check("t6_rdata", rdata_seen, 32'h8765_4321);

    // 7: reset while in ACCESS
    slave_waits = 1000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h040;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("t7_in_access", 32'(penable), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_psel", 32'(psel), 0);
    check("t7_rst_penable", 32'(penable), 0);
    check("t7_rst_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t7_rel_cmd_ready", 32'(cmd_ready), 1);
    repeat (3) @(posedge clk);
    #1 check("t7_no_stale_rsp", 32'(rsp_valid), 0);
    check("t7_no_stale_psel", 32'(psel), 0);

    // 8: normal operation after reset
    do_txn(1'b0, 10'h044, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1);
    check("t8_rdata", rdata_seen, 32'h0BAD_F00D);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
